// File: rtl/uart_echo_responder.sv
// uart_echo_responder: bench-side UART far end; receives 8N1 bytes, buffers them, echoes them XORed with XOR_MASK.
// Ports:
//    clock, resetb            rising-edge clock, asynchronous active-low reset
//    enable                   receiver enable; low aborts any frame being received
//    tx_hold                  blocks the start of new transmit frames
//    uart_rx / uart_tx        serial in / serial out, both idle high
//    rx_valid, rx_data        one-cycle good-frame pulse and last good byte (before the mask)
//    rx_byte_count            good frames received (saturating)
//    frame_error_count        frames with a low stop bit (saturating)
//    fifo_overflow            sticky, set when a good byte is dropped on a full FIFO
//    busy                     either FSM active or FIFO holding data
module uart_echo_responder #(
   parameter int         CLOCKS_PER_BIT  = 16,
   parameter int         FIFO_DEPTH_LOG2 = 3,
   parameter logic [7:0] XOR_MASK        = 8'h00
) (
   input  logic        clock,
   input  logic        resetb,
   input  logic        enable,
   input  logic        tx_hold,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        rx_valid,
   output logic [7:0]  rx_data,
   output logic [15:0] rx_byte_count,
   output logic [7:0]  frame_error_count,
   output logic        fifo_overflow,
   output logic        busy
);
   localparam int TW = $clog2(CLOCKS_PER_BIT);
   localparam int AW = FIFO_DEPTH_LOG2;
   localparam logic [TW-1:0] HALF_LAST = TW'(CLOCKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLOCKS_PER_BIT - 1);
   // The TX stop bit spends one cycle less in STOP; the IDLE cycle that follows supplies the last high
   // cycle, so back-to-back frames carry exactly one full stop bit.
   localparam logic [TW-1:0] STOP_LAST = TW'(CLOCKS_PER_BIT - 2);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   rx_state_t       r_rx_state, w_rx_state;
   tx_state_t       r_tx_state, w_tx_state;
   logic            r_meta, r_sync;
   logic [TW-1:0]   r_rx_timer, w_rx_timer, r_tx_timer, w_tx_timer;
   logic [2:0]      r_rx_bits, w_rx_bits, r_tx_bits, w_tx_bits;
   logic [7:0]      r_rx_shift, w_rx_shift, r_tx_shift, w_tx_shift;
   logic            w_rx_good, w_rx_ferr, w_push, w_pop, w_empty, w_full;
   logic [AW:0]     r_wr_ptr, r_rd_ptr;
   logic [7:0]      r_mem [2**AW];
   logic            r_uart_tx, r_rx_valid, r_ovf;
   logic [7:0]      r_rx_data, r_fe_cnt;
   logic [15:0]     r_rx_cnt;

   assign w_empty = r_wr_ptr == r_rd_ptr;
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   // A pop in the same cycle frees a slot, so a push at full is still accepted then.
   assign w_push  = w_rx_good && (!w_full || w_pop);

   always_comb begin
      w_rx_state = r_rx_state;
      w_rx_timer = r_rx_timer + 1'b1;
      w_rx_bits  = r_rx_bits;
      w_rx_shift = r_rx_shift;
      w_rx_good  = 1'b0;
      w_rx_ferr  = 1'b0;
      if (!enable)
         w_rx_state = RX_IDLE;
      else
         case (r_rx_state)
            RX_IDLE: begin
               w_rx_timer = '0;
               if (!r_sync) w_rx_state = RX_START;
            end
            RX_START:
               if (r_rx_timer == HALF_LAST) begin
                  w_rx_timer = '0;
                  w_rx_bits  = '0;
                  w_rx_state = r_sync ? RX_IDLE : RX_DATA;
               end
            RX_DATA:
               if (r_rx_timer == BIT_LAST) begin
                  w_rx_timer = '0;
                  w_rx_shift = {r_sync, r_rx_shift[7:1]};
                  w_rx_bits  = r_rx_bits + 3'd1;
                  if (r_rx_bits == 3'd7) w_rx_state = RX_STOP;
               end
            RX_STOP:
               if (r_rx_timer == BIT_LAST) begin
                  w_rx_good  = r_sync;
                  w_rx_ferr  = !r_sync;
                  w_rx_state = r_sync ? RX_IDLE : RX_WAIT;
               end
            RX_WAIT:
               if (r_sync) w_rx_state = RX_IDLE;
            default:
               w_rx_state = RX_IDLE;
         endcase
   end

   always_comb begin
      w_tx_state = r_tx_state;
      w_tx_timer = r_tx_timer + 1'b1;
      w_tx_bits  = r_tx_bits;
      w_tx_shift = r_tx_shift;
      w_pop      = 1'b0;
      case (r_tx_state)
         TX_IDLE: begin
            w_tx_timer = '0;
            if (!w_empty && !tx_hold) begin
               w_pop      = 1'b1;
               w_tx_shift = r_mem[r_rd_ptr[AW-1:0]];
               w_tx_state = TX_START;
            end
         end
         TX_START:
            if (r_tx_timer == BIT_LAST) begin
               w_tx_timer = '0;
               w_tx_bits  = '0;
               w_tx_state = TX_DATA;
            end
         TX_DATA:
            if (r_tx_timer == BIT_LAST) begin
               w_tx_timer = '0;
               w_tx_bits  = r_tx_bits + 3'd1;
               w_tx_shift = {1'b0, r_tx_shift[7:1]};
               if (r_tx_bits == 3'd7) w_tx_state = TX_STOP;
            end
         TX_STOP:
            if (r_tx_timer == STOP_LAST) w_tx_state = TX_IDLE;
         default:
            w_tx_state = TX_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetb)
      if (!resetb) begin
         r_meta     <= 1'b1;
         r_sync     <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_tx_state <= TX_IDLE;
         r_rx_timer <= '0;
         r_tx_timer <= '0;
         r_rx_bits  <= '0;
         r_tx_bits  <= '0;
         r_rx_shift <= '0;
         r_tx_shift <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_uart_tx  <= 1'b1;
         r_rx_valid <= 1'b0;
         r_rx_data  <= '0;
         r_rx_cnt   <= '0;
         r_fe_cnt   <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_meta     <= uart_rx;
         r_sync     <= r_meta;
         r_rx_state <= w_rx_state;
         r_tx_state <= w_tx_state;
         r_rx_timer <= w_rx_timer;
         r_tx_timer <= w_tx_timer;
         r_rx_bits  <= w_rx_bits;
         r_tx_bits  <= w_tx_bits;
         r_rx_shift <= w_rx_shift;
         r_tx_shift <= w_tx_shift;
         r_uart_tx  <= (r_tx_state == TX_START) ? 1'b0 : (r_tx_state == TX_DATA) ? r_tx_shift[0] : 1'b1;
         r_rx_valid <= w_rx_good;
         if (w_rx_good) r_rx_data <= r_rx_shift;
         if (w_rx_good && r_rx_cnt != 16'hFFFF) r_rx_cnt <= r_rx_cnt + 16'd1;
         if (w_rx_ferr && r_fe_cnt != 8'hFF) r_fe_cnt <= r_fe_cnt + 8'd1;
         if (w_rx_good && w_full && !w_pop) r_ovf <= 1'b1;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end

   // Storage needs no reset: the pointers alone define which entries are valid.
   always_ff @(posedge clock)
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_rx_shift ^ XOR_MASK;

   assign uart_tx           = r_uart_tx;
   assign rx_valid          = r_rx_valid;
   assign rx_data           = r_rx_data;
   assign rx_byte_count     = r_rx_cnt;
   assign frame_error_count = r_fe_cnt;
   assign fifo_overflow     = r_ovf;
   assign busy              = (r_rx_state != RX_IDLE) || (r_tx_state != TX_IDLE) || !w_empty;
endmodule

// File: tb/tb_uart_echo_responder.sv
// tb_uart_echo_responder: scoreboard bench for uart_echo_responder, one instance unmasked, one with XOR_MASK=FF.
module tb_uart_echo_responder;
   localparam int CPB = 16;

   logic clock = 1'b0, resetb = 1'b0, enable = 1'b1, tx_hold = 1'b0, rx = 1'b1, rx_x = 1'b1;
   logic uart_tx, rx_valid, ovf, busy, tx_x, rx_valid_x, ovf_x, busy_x;
   logic [7:0] rx_data, fe_cnt, rx_data_x, fe_cnt_x;
   logic [15:0] rx_cnt, rx_cnt_x;
   int n_vec = 0, n_err = 0, n_rxv = 0;
   logic [7:0] q0[$], q1[$];
   bit aborted[2];

   always #5 clock = ~clock;

   uart_echo_responder #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(3), .XOR_MASK(8'h00)) dut (
      .clock(clock), .resetb(resetb), .enable(enable), .tx_hold(tx_hold), .uart_rx(rx),
      .uart_tx(uart_tx), .rx_valid(rx_valid), .rx_data(rx_data), .rx_byte_count(rx_cnt),
      .frame_error_count(fe_cnt), .fifo_overflow(ovf), .busy(busy));

   uart_echo_responder #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(3), .XOR_MASK(8'hFF)) dut_x (
      .clock(clock), .resetb(resetb), .enable(enable), .tx_hold(tx_hold), .uart_rx(rx_x),
      .uart_tx(tx_x), .rx_valid(rx_valid_x), .rx_data(rx_data_x), .rx_byte_count(rx_cnt_x),
      .frame_error_count(fe_cnt_x), .fifo_overflow(ovf_x), .busy(busy_x));

   always @(negedge clock) if (rx_valid === 1'b1) n_rxv <= n_rxv + 1;
   always @(negedge resetb) begin
      aborted[0] <= 1'b1;
      aborted[1] <= 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_rx(input bit sel, input logic v);
      if (sel) rx_x = v;
      else rx = v;
   endtask

   task automatic send(input bit sel, input logic [7:0] b, input logic stop);
      set_rx(sel, 1'b0);
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         set_rx(sel, b[i]);
         repeat (CPB) @(negedge clock);
      end
      set_rx(sel, stop);
      repeat (CPB) @(negedge clock);
      set_rx(sel, 1'b1);
   endtask

   // Decodes every frame on one uart_tx line and compares it to the head of that line's queue.
   task automatic monitor(input bit sel);
      logic [7:0] b, e;
      logic s;
      int qs;
      forever begin
         @(negedge clock);
         if ((sel ? tx_x : uart_tx) === 1'b0) begin
            aborted[sel] = 1'b0;
            repeat (CPB / 2) @(negedge clock);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clock);
               b[i] = sel ? tx_x : uart_tx;
            end
            repeat (CPB) @(negedge clock);
            s = sel ? tx_x : uart_tx;
            if (!aborted[sel]) begin
               qs = sel ? q1.size() : q0.size();
               chk("tx_frame_expected", 32'(qs != 0), 32'd1);
               if (qs != 0) begin
                  e = sel ? q1.pop_front() : q0.pop_front();
                  chk("tx_byte", 32'(b), 32'(e));
                  chk("tx_stop", 32'(s), 32'd1);
               end
            end
         end
      end
   endtask

   task automatic wait_quiet();
      for (int i = 0; i < 5000 && (busy || busy_x || q0.size() != 0 || q1.size() != 0); i++)
         @(negedge clock);
      repeat (2 * CPB) @(negedge clock);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("q_drained", 32'(q0.size() + q1.size()), 32'd0);
   endtask

   // rx_valid is a single pulse and the echo start bit begins exactly two cycles after it.
   task automatic lat_check();
      for (int i = 0; i < 400 && rx_valid !== 1'b1; i++) @(negedge clock);
      chk("rx_valid_seen", 32'(rx_valid), 32'd1);
      @(negedge clock);
      chk("rx_valid_pulse", 32'(rx_valid), 32'd0);
      chk("tx_high_lat1", 32'(uart_tx), 32'd1);
      @(negedge clock);
      chk("tx_fall_lat2", 32'(uart_tx), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      resetb = 1'b0;
      q0.delete();
      q1.delete();
      repeat (3) @(negedge clock);
      resetb = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         monitor(1'b0);
         monitor(1'b1);
      join_none
      repeat (3) @(negedge clock);
      chk("rst_uart_tx", 32'(uart_tx), 32'd1);
      chk("rst_tx_x", 32'(tx_x), 32'd1);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      chk("rst_rx_cnt", 32'(rx_cnt), 32'd0);
      chk("rst_fe_cnt", 32'(fe_cnt), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      resetb = 1'b1;
      repeat (4) @(negedge clock);

      // plain echo
      q0.push_back(8'h55);
      fork
         send(1'b0, 8'h55, 1'b1);
         lat_check();
      join
      wait_quiet();
      chk("t1_rx_data", 32'(rx_data), 32'h55);
      chk("t1_rx_cnt", 32'(rx_cnt), 32'd1);

      // masked echo
      q1.push_back(8'h5A);
      send(1'b1, 8'hA5, 1'b1);
      wait_quiet();
      chk("t2_rx_data", 32'(rx_data_x), 32'hA5);
      chk("t2_rx_cnt", 32'(rx_cnt_x), 32'd1);

      // framing error, then recovery
      send(1'b0, 8'h3C, 1'b0);
      repeat (2 * CPB) @(negedge clock);
      chk("t3_fe_cnt", 32'(fe_cnt), 32'd1);
      chk("t3_rx_cnt", 32'(rx_cnt), 32'd1);
      chk("t3_rx_data_held", 32'(rx_data), 32'h55);
      chk("t3_busy", 32'(busy), 32'd0);
      q0.push_back(8'h12);
      send(1'b0, 8'h12, 1'b1);
      wait_quiet();
      chk("t3_rx_data", 32'(rx_data), 32'h12);
      chk("t3_rx_cnt2", 32'(rx_cnt), 32'd2);

      // short low glitch is a false start
      rx = 1'b0;
      repeat (4) @(negedge clock);
      rx = 1'b1;
      repeat (4 * CPB) @(negedge clock);
      chk("t4_rxv_pulses", 32'(n_rxv), 32'd2);
      chk("t4_rx_cnt", 32'(rx_cnt), 32'd2);
      chk("t4_fe_cnt", 32'(fe_cnt), 32'd1);
      chk("t4_uart_tx", 32'(uart_tx), 32'd1);
      chk("t4_busy", 32'(busy), 32'd0);

      // overflow under tx_hold
      do_reset();
      chk("t5_rx_cnt_rst", 32'(rx_cnt), 32'd0);
      tx_hold = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) q0.push_back(8'(i));
         send(1'b0, 8'(i), 1'b1);
         if (i == 8) chk("t5_ovf_at8", 32'(ovf), 32'd0);
      end
      repeat (2 * CPB) @(negedge clock);
      chk("t5_ovf", 32'(ovf), 32'd1);
      chk("t5_rx_cnt", 32'(rx_cnt), 32'd9);
      chk("t5_held_tx", 32'(uart_tx), 32'd1);
      chk("t5_busy", 32'(busy), 32'd1);
      tx_hold = 1'b0;
      wait_quiet();
      chk("t5_ovf_sticky", 32'(ovf), 32'd1);

      // reset in the middle of a transmitted data bit (bit 2 of 0x3B is 0)
      q0.push_back(8'h3B);
      send(1'b0, 8'h3B, 1'b1);
      for (int i = 0; i < 400 && uart_tx !== 1'b0; i++) @(negedge clock);
      chk("t6_tx_started", 32'(uart_tx), 32'd0);
      repeat (CPB + 2 * CPB + CPB / 2) @(negedge clock);
      chk("t6_tx_bit2_low", 32'(uart_tx), 32'd0);
      chk("t6_busy_mid", 32'(busy), 32'd1);
      #2 resetb = 1'b0;
      q0.delete();
      #1;
      chk("t6_tx_high", 32'(uart_tx), 32'd1);
      chk("t6_rx_cnt", 32'(rx_cnt), 32'd0);
      chk("t6_ovf", 32'(ovf), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clock);
      resetb = 1'b1;
      repeat (10 * CPB) @(negedge clock);
      q0.push_back(8'hC6);
      send(1'b0, 8'hC6, 1'b1);
      wait_quiet();
      chk("t6_rx_data", 32'(rx_data), 32'hC6);
      chk("t6_rx_cnt2", 32'(rx_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
